// File: rtl/uart_tx.sv
// uart_tx: asynchronous serial transmitter, 8N1 frames (start, 8 data bits LSB
// first, stop) with its own bit-period divider. Every bit lasts BAUDRATE clocks.
// Optional parity bit between data and stop when UART_TX_PARITY_EN is defined.
module uart_tx #(
    parameter int unsigned BAUDRATE = 104
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [7:0] data,
    output logic       tx,
    output logic       ready
);

    localparam int unsigned    DW       = (BAUDRATE > 1) ? $clog2(BAUDRATE) : 1;
    localparam logic [DW-1:0]  DIV_LAST = DW'(BAUDRATE - 1);

`ifdef UART_TX_PARITY_EN
    localparam bit PARITY_ODD = 1'b0;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        STOP   = 3'd3,
        PARITY = 3'd4
    } state_t;

    logic          par_bit;
`else
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        DATA  = 3'd2,
        STOP  = 3'd3
    } state_t;
`endif

    state_t        state;
    logic [DW-1:0] div_cnt;
    logic [2:0]    bit_cnt;
    logic [7:0]    shreg;
    logic          tick;

    // End of the current bit period; transitions happen on the following edge.
    assign tick = (div_cnt == DIV_LAST);

    // Frame sequencer: divider, shift register and registered tx/ready.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            tx      <= 1'b1;
            ready   <= 1'b1;
            div_cnt <= '0;
            bit_cnt <= '0;
            shreg   <= '0;
`ifdef UART_TX_PARITY_EN
            par_bit <= 1'b0;
`endif
        end else begin
            // Divider only runs while a frame is in flight.
            if (state == IDLE || tick) begin
                div_cnt <= '0;
            end else begin
                div_cnt <= div_cnt + 1'b1;
            end

            case (state)
                IDLE: begin
                    tx    <= 1'b1;
                    ready <= 1'b1;
                    if (start && ready) begin
                        shreg <= data;
`ifdef UART_TX_PARITY_EN
                        par_bit <= (^data) ^ PARITY_ODD;
`endif
                        tx    <= 1'b0;
                        ready <= 1'b0;
                        state <= START;
                    end
                end

                START: begin
                    if (tick) begin
                        tx      <= shreg[0];
                        bit_cnt <= '0;
                        state   <= DATA;
                    end
                end

                DATA: begin
                    if (tick) begin
                        if (bit_cnt != 3'd7) begin
                            shreg   <= {1'b0, shreg[7:1]};
                            tx      <= shreg[1];
                            bit_cnt <= bit_cnt + 1'b1;
                        end else begin
`ifdef UART_TX_PARITY_EN
                            tx    <= par_bit;
                            state <= PARITY;
`else
                            tx    <= 1'b1;
                            state <= STOP;
`endif
                        end
                    end
                end

`ifdef UART_TX_PARITY_EN
                PARITY: begin
                    if (tick) begin
                        tx    <= 1'b1;
                        state <= STOP;
                    end
                end
`endif

                STOP: begin
                    tx <= 1'b1;
                    if (tick) begin
                        ready <= 1'b1;
                        state <= IDLE;
                    end
                end

                default: begin
                    tx    <= 1'b1;
                    ready <= 1'b1;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: bench for uart_tx with two instances (BAUDRATE 4 and 104).
// A frame-level model predicts tx/ready every cycle; directed scenarios add
// hand-computed frame and timing expectations.
module tb_uart_tx;

    localparam int unsigned B0 = 4;
    localparam int unsigned B1 = 104;

`ifdef UART_TX_PARITY_EN
    localparam int unsigned FB       = 11;
    localparam logic [10:0] L55      = 11'b10010101010;
    localparam logic [10:0] L80      = 11'b11100000000;
    localparam logic [10:0] LA5      = 11'b10101001010;
    localparam logic [10:0] L3C      = 11'b10001111000;
    localparam logic [7:0]  RDATA    = 8'h07;
    localparam logic [10:0] LRD      = 11'b11000001110;
    localparam int unsigned LOW_CYC  = 44;
    localparam int unsigned B2B_POS  = 44;
`else
    localparam int unsigned FB       = 10;
    localparam logic [10:0] L55      = 11'b01010101010;
    localparam logic [10:0] L80      = 11'b01100000000;
    localparam logic [10:0] LA5      = 11'b01101001010;
    localparam logic [10:0] L3C      = 11'b01001111000;
    localparam logic [7:0]  RDATA    = 8'h0F;
    localparam logic [10:0] LRD      = 11'b01000011110;
    localparam int unsigned LOW_CYC  = 40;
    localparam int unsigned B2B_POS  = 40;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start4 = 1'b0;
    logic       start104 = 1'b0;
    logic [7:0] data4 = 8'h00;
    logic [7:0] data104 = 8'h00;
    logic       tx4, ready4, tx104, ready104;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    uart_tx #(.BAUDRATE(B0)) dut4 (
        .clk(clk), .rst(rst), .start(start4), .data(data4), .tx(tx4), .ready(ready4)
    );

    uart_tx #(.BAUDRATE(B1)) dut104 (
        .clk(clk), .rst(rst), .start(start104), .data(data104), .tx(tx104), .ready(ready104)
    );

    // ---------------- frame-level model ----------------
    int          n = 0;
    bit          m_active [2] = '{1'b0, 1'b0};
    int          m_e0     [2] = '{0, 0};
    logic [10:0] m_frame  [2] = '{11'h7FF, 11'h7FF};

    function automatic int baud(input int i);
        return (i == 0) ? int'(B0) : int'(B1);
    endfunction

    // Line bits in transmission order: bit j of the result is frame bit j.
    function automatic logic [10:0] make_frame(input logic [7:0] d);
`ifdef UART_TX_PARITY_EN
        return {1'b1, ^d, d, 1'b0};
`else
        return {2'b11, d, 1'b0};
`endif
    endfunction

    // Model: a frame occupies FB*baud edges starting at the accepting edge.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_active[0] <= 1'b0;
            m_active[1] <= 1'b0;
        end else begin
            n <= n + 1;
            for (int i = 0; i < 2; i++) begin
                if (!m_active[i]) begin
                    if (((i == 0) ? start4 : start104) === 1'b1) begin
                        m_active[i] <= 1'b1;
                        m_e0[i]     <= n + 1;
                        m_frame[i]  <= make_frame((i == 0) ? data4 : data104);
                    end
                end else if ((n + 1 - m_e0[i]) == int'(FB) * baud(i)) begin
                    m_active[i] <= 1'b0;
                end
            end
        end
    end

    function automatic logic exp_tx(input int i);
        int t;
        if (!m_active[i]) return 1'b1;
        t = n - m_e0[i];
        return m_frame[i][t / baud(i)];
    endfunction

    // ---------------- checking ----------------
    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", nm, act, exp, $time);
        end
    endtask

    task automatic cmp_model();
        check("tx4_model",     32'(tx4),      32'(exp_tx(0)));
        check("ready4_model",  32'(ready4),   32'(!m_active[0]));
        check("tx104_model",   32'(tx104),    32'(exp_tx(1)));
        check("ready104_model",32'(ready104), 32'(!m_active[1]));
    endtask

    task automatic step();
        @(negedge clk);
        cmp_model();
    endtask

    // ---------------- directed stimulus ----------------
    initial begin
        logic [10:0] fr;
        logic [10:0] fr2;
        int          lowc;
        int          highc;
        int          hpos;
        int          falls;
        logic        ptx;

        // Reset and idle
        repeat (3) step();
        rst = 1'b0;
        repeat (3) begin
            step();
            check("idle_tx", 32'(tx4), 32'd1);
            check("idle_ready", 32'(ready4), 32'd1);
        end

        // 0x55 at BAUDRATE=4
        data4 = 8'h55; start4 = 1'b1;
        step();
        check("acc_tx", 32'(tx4), 32'd0);
        check("acc_ready", 32'(ready4), 32'd0);
        start4 = 1'b0;
        fr = '0; lowc = 1;
        for (int t = 1; t < int'(FB * B0) + 8; t++) begin
            step();
            if (!ready4) lowc++;
            if ((t % int'(B0)) == int'(B0 / 2) && (t / int'(B0)) < int'(FB)) fr[t / int'(B0)] = tx4;
        end
        check("frame55", 32'(fr), 32'(L55));
        check("low55", 32'(lowc), 32'(LOW_CYC));

        // 0x80 at BAUDRATE=104, bit-centre sampling, data changed after accept
        data104 = 8'h80; start104 = 1'b1;
        step();
        start104 = 1'b0; data104 = 8'hFF;
        fr = '0;
        for (int t = 1; t < int'(FB * B1) + 4; t++) begin
            step();
            if (t >= 52 && ((t - 52) % 104) == 0 && ((t - 52) / 104) < int'(FB)) fr[(t - 52) / 104] = tx104;
        end
        check("frame80", 32'(fr), 32'(L80));

        // Back-to-back 0xA5 then 0x3C with start held
        data4 = 8'hA5; start4 = 1'b1;
        step();
        data4 = 8'h3C;
        fr = '0; fr2 = '0; highc = 0; hpos = -1;
        for (int t = 1; t < 2 * int'(FB * B0) + 4; t++) begin
            step();
            if (t <= 2 * int'(FB * B0) && ready4) begin highc++; hpos = t; end
            if (t == int'(FB * B0) + 1) begin
                check("b2b_second_start", 32'(tx4), 32'd0);
                start4 = 1'b0;
            end
            if (t < int'(FB * B0) && (t % 4) == 2) fr[t / 4] = tx4;
            if (t > int'(FB * B0) && ((t - int'(FB * B0) - 1) % 4) == 2 && ((t - int'(FB * B0) - 1) / 4) < int'(FB))
                fr2[(t - int'(FB * B0) - 1) / 4] = tx4;
        end
        check("b2b_ready_cycles", 32'(highc), 32'd1);
        check("b2b_ready_pos", 32'(hpos), 32'(B2B_POS));
        check("frameA5", 32'(fr), 32'(LA5));
        check("frame3C", 32'(fr2), 32'(L3C));

        // Start while busy is ignored
        data4 = 8'hFF; start4 = 1'b1;
        step();
        start4 = 1'b0;
        falls = 0; ptx = tx4;
        for (int t = 1; t < int'(FB * B0) + 10; t++) begin
            step();
            if (ptx && !tx4) falls++;
            ptx = tx4;
            if (t == 9) begin start4 = 1'b1; data4 = 8'h00; end
            if (t == 10) start4 = 1'b0;
        end
        check("busy_extra_frames", 32'(falls), 32'd0);
        check("busy_end_tx", 32'(tx4), 32'd1);
        check("busy_end_ready", 32'(ready4), 32'd1);

        // Reset mid-frame, then a clean frame
        data4 = 8'h33; start4 = 1'b1;
        step();
        start4 = 1'b0;
        repeat (14) step();
        check("pre_rst_tx", 32'(tx4), 32'd0);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("rst_tx", 32'(tx4), 32'd1);
        check("rst_ready", 32'(ready4), 32'd1);
        step();
        step();
        rst = 1'b0;
        step();
        check("post_rst_tx", 32'(tx4), 32'd1);
        check("post_rst_ready", 32'(ready4), 32'd1);
        data4 = RDATA; start4 = 1'b1;
        step();
        start4 = 1'b0;
        fr = '0; lowc = 1;
        for (int t = 1; t < int'(FB * B0) + 6; t++) begin
            step();
            if (!ready4) lowc++;
            if ((t % 4) == 2 && (t / 4) < int'(FB)) fr[t / 4] = tx4;
        end
        check("frame_after_rst", 32'(fr), 32'(LRD));
        check("low_after_rst", 32'(lowc), 32'(LOW_CYC));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
